// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan decoder.
// Holds the active-low segment codes for digits 0..9, the active-low
// one-hot digit-select codes, the receive FSM state type and the default
// settle time.
package seg7_pkg;

  localparam int SETTLE_DEF = 4;

  // Segment codes, active-low, bit order {dp,g,f,e,d,c,b,a}, dp off.
  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80;
  localparam logic [7:0] SEG_9 = 8'h90;

  // Entry i holds the pattern for digit i.
  localparam logic [9:0][7:0] SEG_CODES = {SEG_9, SEG_8, SEG_7, SEG_6, SEG_5,
                                           SEG_4, SEG_3, SEG_2, SEG_1, SEG_0};

  // Digit-select codes, one-hot active-low; digit 0 is the ones digit.
  localparam logic [3:0] CTRL_D0    = 4'b1110;
  localparam logic [3:0] CTRL_D1    = 4'b1101;
  localparam logic [3:0] CTRL_D2    = 4'b1011;
  localparam logic [3:0] CTRL_D3    = 4'b0111;
  localparam logic [3:0] CTRL_BLANK = 4'b1111;

  typedef enum logic [1:0] {
    ST_SYNC,
    ST_COLLECT,
    ST_EMIT
  } state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational decode of one active-low segment pattern back to BCD.
// Ports:
//   pattern  in  8  segments, active-low, {dp,g,f,e,d,c,b,a}
//   bcd      out 4  decoded digit, 4'hF when the pattern is not a decimal digit
//   dp       out 1  decimal point lit (pattern bit 7 low)
//   is_digit out 1  bits[6:0] matched one of the ten digit shapes
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [7:0] pattern,
  output logic [3:0] bcd,
  output logic       dp,
  output logic       is_digit
);

  // The dp segment is excluded from matching so a lit point never turns a
  // valid digit into an error.
  always_comb begin
    bcd      = 4'hF;
    is_digit = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (pattern[6:0] == SEG_CODES[i][6:0]) begin
        bcd      = 4'(i);
        is_digit = 1'b1;
      end
    end
  end

  assign dp = ~pattern[7];

endmodule

// File: rtl/seven_seg_scan_decoder.sv
// Receive side of a multiplexed 4-digit seven-segment bus. Registers the
// digit-select/segment pair, waits for each pair to stay stable for SETTLE
// cycles, decodes it and assembles digits 3..0 into a packed-BCD frame.
// Ports:
//   clk          in   1   rising-edge clock
//   rst          in   1   asynchronous active-low reset
//   ctrl         in   4   digit select, one-hot active-low (1110 = ones)
//   segment      in   8   segments, active-low, {dp,g,f,e,d,c,b,a}
//   value        out  16  {thousands,hundreds,tens,ones} of last frame
//   value_valid  out  1   one-cycle pulse when value updates
//   dp           out  4   decimal points of last frame, active-high
//   pattern_err  out  1   sticky: a captured pattern was not a digit
//   sync_loss    out  1   one-cycle pulse on an out-of-order digit
module seven_seg_scan_decoder
  import seg7_pkg::*;
#(
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  ctrl,
  input  logic [7:0]  segment,
  output logic [15:0] value,
  output logic        value_valid,
  output logic [3:0]  dp,
  output logic        pattern_err,
  output logic        sync_loss
);

  logic [3:0]      ctrl_q;
  logic [7:0]      seg_q;
  logic [7:0]      cnt_q, cnt_d;
  state_e          state_q, state_d;
  logic [1:0]      exp_q, exp_d;
  logic [3:0][3:0] frame_q, frame_d;
  logic [3:0]      fdp_q, fdp_d;
  logic [15:0]     value_q, value_d;
  logic [3:0]      dp_q, dp_d;
  logic            valid_q, valid_d;
  logic            perr_q, perr_d;
  logic            sloss_q, sloss_d;

  logic            changed, capture, cap_ok;
  logic [3:0]      cap_ctrl;
  logic [7:0]      cap_seg;
  logic [1:0]      idx;
  logic            idx_vld;
  logic [3:0]      dec_bcd;
  logic            dec_dp, dec_is_digit;

  // The counter tracks how long the registered pair has been held; it is
  // computed against the incoming pair so capture lands on the edge where
  // the count reaches SETTLE.
  assign changed = {ctrl, segment} != {ctrl_q, seg_q};

  always_comb begin
    if (changed)              cnt_d = 8'd1;
    else if (cnt_q == 8'hFF)  cnt_d = cnt_q;
    else                      cnt_d = cnt_q + 8'd1;
  end

  // A saturated counter holds its value, so the second term blocks repeat
  // captures when SETTLE is 255.
  assign capture = (cnt_d == 8'(SETTLE)) && (changed || (cnt_d != cnt_q));

  // With SETTLE of 1 the capture coincides with the change itself, so the
  // pair being loaded is the one that settled.
  assign cap_ctrl = (SETTLE == 1) ? ctrl    : ctrl_q;
  assign cap_seg  = (SETTLE == 1) ? segment : seg_q;

  always_comb begin
    idx     = 2'd0;
    idx_vld = 1'b1;
    case (cap_ctrl)
      CTRL_D0: idx = 2'd0;
      CTRL_D1: idx = 2'd1;
      CTRL_D2: idx = 2'd2;
      CTRL_D3: idx = 2'd3;
      default: idx_vld = 1'b0;
    endcase
  end

  assign cap_ok = capture && idx_vld;

  seg7_pattern_decode u_dec (
    .pattern  (cap_seg),
    .bcd      (dec_bcd),
    .dp       (dec_dp),
    .is_digit (dec_is_digit)
  );

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    frame_d = frame_q;
    fdp_d   = fdp_q;
    value_d = value_q;
    dp_d    = dp_q;
    valid_d = 1'b0;
    sloss_d = 1'b0;
    perr_d  = perr_q | (cap_ok & ~dec_is_digit);
    case (state_q)
      ST_SYNC: begin
        if (cap_ok && idx == 2'd3) begin
          frame_d[3] = dec_bcd;
          fdp_d[3]   = dec_dp;
          exp_d      = 2'd2;
          state_d    = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (cap_ok) begin
          if (idx == exp_q) begin
            frame_d[idx] = dec_bcd;
            fdp_d[idx]   = dec_dp;
            if (exp_q == 2'd0) state_d = ST_EMIT;
            else               exp_d   = exp_q - 2'd1;
          end else begin
            // Out of order: a fresh digit 3 restarts the frame in place.
            sloss_d = 1'b1;
            if (idx == 2'd3) begin
              frame_d[3] = dec_bcd;
              fdp_d[3]   = dec_dp;
              exp_d      = 2'd2;
            end else begin
              state_d = ST_SYNC;
            end
          end
        end
      end
      ST_EMIT: begin
        value_d = frame_q;
        dp_d    = fdp_q;
        valid_d = 1'b1;
        state_d = ST_SYNC;
      end
      default: state_d = ST_SYNC;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q  <= CTRL_BLANK;
      seg_q   <= 8'hFF;
      cnt_q   <= 8'd0;
      state_q <= ST_SYNC;
      exp_q   <= 2'd0;
      frame_q <= '0;
      fdp_q   <= 4'h0;
      value_q <= 16'h0000;
      dp_q    <= 4'h0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      sloss_q <= 1'b0;
    end else begin
      ctrl_q  <= ctrl;
      seg_q   <= segment;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      exp_q   <= exp_d;
      frame_q <= frame_d;
      fdp_q   <= fdp_d;
      value_q <= value_d;
      dp_q    <= dp_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      sloss_q <= sloss_d;
    end
  end

  assign value       = value_q;
  assign value_valid = valid_q;
  assign dp          = dp_q;
  assign pattern_err = perr_q;
  assign sync_loss   = sloss_q;

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Bench for seven_seg_scan_decoder: table of whole-frame vectors, a few
// hand-written timing/corner sequences, and a randomized segment stream
// checked against a frame-level reference model.
module tb_seven_seg_scan_decoder;

  localparam int SETTLE = 4;
  localparam int NRND   = 250;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  ctrl = 4'hF;
  logic [7:0]  segment = 8'hFF;
  logic [15:0] value;
  logic        value_valid;
  logic [3:0]  dp;
  logic        pattern_err;
  logic        sync_loss;

  seven_seg_scan_decoder #(.SETTLE(SETTLE)) dut (
    .clk         (clk),
    .rst         (rst),
    .ctrl        (ctrl),
    .segment     (segment),
    .value       (value),
    .value_valid (value_valid),
    .dp          (dp),
    .pattern_err (pattern_err),
    .sync_loss   (sync_loss)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int nvalid = 0;
  int nsloss = 0;
  logic chk_on = 1'b0;
  logic [19:0] expq[$];
  logic [19:0] exp_e;

  logic [7:0] segtab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                              8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame scoreboard and pulse counters.
  always @(negedge clk) begin
    if (value_valid === 1'b1) begin
      nvalid++;
      if (chk_on) begin
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rnd_extra_frame: got %0h expected none", {dp, value});
        end else begin
          exp_e = expq.pop_front();
          check("rnd_frame", {12'h0, dp, value}, {12'h0, exp_e});
        end
      end
    end
    if (sync_loss === 1'b1) nsloss++;
  end

  function automatic logic [3:0] cmask(input int i);
    logic [3:0] one;
    one = 4'b0001 << i;
    return ~one;
  endfunction

  task automatic drive(input logic [3:0] c, input logic [7:0] s, input int h);
    ctrl = c;
    segment = s;
    repeat (h) @(negedge clk);
  endtask

  task automatic scan(input logic [7:0] p3, input logic [7:0] p2,
                      input logic [7:0] p1, input logic [7:0] p0, input int h);
    drive(4'b0111, p3, h);
    drive(4'b1011, p2, h);
    drive(4'b1101, p1, h);
    drive(4'b1110, p0, h);
  endtask

  // Reference helpers: digit index of a one-hot-low select (-1 otherwise)
  // and digit value of a pattern (15 when not a decimal shape).
  function automatic int sel_idx(input logic [3:0] c);
    int zeros = 0;
    int pos = -1;
    for (int i = 0; i < 4; i++)
      if (c[i] == 1'b0) begin zeros++; pos = i; end
    return (zeros == 1) ? pos : -1;
  endfunction

  function automatic logic [3:0] digit_of(input logic [7:0] s);
    for (int i = 0; i < 10; i++)
      if ((s | 8'h80) == segtab[i]) return 4'(i);
    return 4'hF;
  endfunction

  typedef struct {
    logic [7:0]  p3, p2, p1, p0;
    int          hold;
    int          exp_frames;
    logic [15:0] exp_value;
    logic [3:0]  exp_dp;
    logic        exp_perr;
  } vec_t;

  vec_t vecs [5];

  logic [3:0] rc [NRND];
  logic [7:0] rs [NRND];
  int         rh [NRND];

  initial begin
    int v0, s0, first, highs, msl, mst, idx;
    logic [3:0] pc, c, d, mdp;
    logic [7:0] ps, s;
    logic [3:0] md [4];
    logic mperr;
    int scanp;

    vecs[0] = '{8'hF9, 8'hA4, 8'hB0, 8'h99, 6, 1, 16'h1234, 4'h0, 1'b0};
    vecs[1] = '{8'hC0, 8'hC0, 8'hC0, 8'hC0, 4, 1, 16'h0000, 4'h0, 1'b0};
    vecs[2] = '{8'h90, 8'h90, 8'h90, 8'h90, 3, 0, 16'h0000, 4'h0, 1'b0};
    vecs[3] = '{8'h10, 8'h80, 8'h82, 8'h92, 5, 1, 16'h9865, 4'h8, 1'b0};
    vecs[4] = '{8'hF9, 8'hF9, 8'hFF, 8'hF9, 5, 1, 16'h11F1, 4'h0, 1'b1};

    repeat (3) @(negedge clk);
    check("reset_value", value, 16'h0000);
    check("reset_valid", value_valid, 1'b0);
    check("reset_dp", dp, 4'h0);
    check("reset_perr", pattern_err, 1'b0);
    check("reset_sloss", sync_loss, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Whole-frame vectors.
    for (int i = 0; i < 5; i++) begin
      v0 = nvalid;
      s0 = nsloss;
      scan(vecs[i].p3, vecs[i].p2, vecs[i].p1, vecs[i].p0, vecs[i].hold);
      drive(4'hF, 8'hFF, 4);
      check($sformatf("vec%0d_frames", i), nvalid - v0, vecs[i].exp_frames);
      check($sformatf("vec%0d_value", i), value, vecs[i].exp_value);
      check($sformatf("vec%0d_dp", i), dp, vecs[i].exp_dp);
      check($sformatf("vec%0d_perr", i), pattern_err, vecs[i].exp_perr);
      check($sformatf("vec%0d_sloss", i), nsloss - s0, 0);
    end

    // Digits 3,2,0: sync loss on digit 0, no frame; then clean 9999.
    v0 = nvalid; s0 = nsloss;
    drive(4'b0111, 8'h99, 5);
    drive(4'b1011, 8'h99, 5);
    drive(4'b1110, 8'h99, 5);
    drive(4'hF, 8'hFF, 4);
    check("skip_sloss", nsloss - s0, 1);
    check("skip_frames", nvalid - v0, 0);
    scan(8'h90, 8'h90, 8'h90, 8'h90, 5);
    drive(4'hF, 8'hFF, 4);
    check("resync_frames", nvalid - v0, 1);
    check("resync_value", value, 16'h9999);

    // Latency: value_valid seen after edge n+SETTLE, for exactly one cycle.
    drive(4'b0111, 8'hF8, 5);
    drive(4'b1011, 8'hF8, 5);
    drive(4'b1101, 8'hF8, 5);
    ctrl = 4'b1110; segment = 8'h80;
    first = 0; highs = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (value_valid === 1'b1) begin
        highs++;
        if (first == 0) first = k;
      end
    end
    check("latency_edge", first, SETTLE + 1);
    check("latency_width", highs, 1);
    check("latency_value", value, 16'h7778);
    drive(4'hF, 8'hFF, 2);

    // Loopback wrap: 9999 immediately followed by 0000.
    v0 = nvalid;
    scan(8'h90, 8'h90, 8'h90, 8'h90, 4);
    drive(4'b0111, 8'hC0, 1);
    check("wrap_first_valid", value_valid, 1'b1);
    check("wrap_first_value", value, 16'h9999);
    drive(4'b0111, 8'hC0, 3);
    drive(4'b1011, 8'hC0, 4);
    drive(4'b1101, 8'hC0, 4);
    drive(4'b1110, 8'hC0, 4);
    drive(4'hF, 8'hFF, 4);
    check("wrap_frames", nvalid - v0, 2);
    check("wrap_second_value", value, 16'h0000);

    // Static digit 3 for far longer than the counter range: one capture only.
    v0 = nvalid; s0 = nsloss;
    drive(4'b0111, 8'hF9, 300);
    drive(4'b1011, 8'hF9, 4);
    drive(4'b1101, 8'hF9, 4);
    drive(4'b1110, 8'hF9, 4);
    drive(4'hF, 8'hFF, 4);
    check("static_sloss", nsloss - s0, 0);
    check("static_frames", nvalid - v0, 1);
    check("static_value", value, 16'h1111);

    // Reset mid-frame: outputs clear at once, partial frame is lost.
    drive(4'b0111, 8'h92, 5);
    drive(4'b1011, 8'h92, 2);
    #2 rst = 1'b0;
    #1;
    check("midrst_value", value, 16'h0000);
    check("midrst_valid", value_valid, 1'b0);
    check("midrst_dp", dp, 4'h0);
    check("midrst_perr", pattern_err, 1'b0);
    check("midrst_sloss", sync_loss, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    v0 = nvalid;
    drive(4'b1101, 8'h92, 5);
    drive(4'b1110, 8'h92, 5);
    drive(4'hF, 8'hFF, 4);
    check("midrst_partial_frames", nvalid - v0, 0);
    scan(8'h92, 8'h92, 8'h92, 8'h92, 5);
    drive(4'hF, 8'hFF, 4);
    check("midrst_next_value", value, 16'h5555);

    // Randomized stream against the frame-level model.
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    pc = 4'hF; ps = 8'hFF; scanp = 3;
    for (int i = 0; i < NRND; i++) begin
      do begin
        int r;
        r = $urandom_range(99);
        if (r < 60) begin
          c = cmask(scanp);
          scanp = (scanp == 0) ? 3 : scanp - 1;
        end else if (r < 85) begin
          c = cmask($urandom_range(3));
        end else if (r < 92) begin
          c = 4'hF;
        end else begin
          c = cmask($urandom_range(3)) & cmask($urandom_range(3));
        end
        if ($urandom_range(4) != 0)
          s = segtab[$urandom_range(9)] & (($urandom_range(1) == 1) ? 8'hFF : 8'h7F);
        else
          s = 8'($urandom);
      end while ({c, s} == {pc, ps});
      rc[i] = c; rs[i] = s;
      rh[i] = ($urandom_range(4) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 8);
      pc = c; ps = s;
    end

    // Model: a pair held SETTLE cycles or more is one captured digit.
    mst = -1; msl = 0; mperr = 1'b0; mdp = 4'h0;
    for (int j = 0; j < 4; j++) md[j] = 4'h0;
    expq.delete();
    for (int i = 0; i < NRND; i++) begin
      idx = sel_idx(rc[i]);
      if (rh[i] >= SETTLE && idx >= 0) begin
        d = digit_of(rs[i]);
        if (d == 4'hF) mperr = 1'b1;
        if (mst < 0) begin
          if (idx == 3) begin md[3] = d; mdp[3] = ~rs[i][7]; mst = 2; end
        end else if (idx == mst) begin
          md[idx] = d; mdp[idx] = ~rs[i][7];
          if (idx == 0) begin
            expq.push_back({mdp, md[3], md[2], md[1], md[0]});
            mst = -1;
          end else begin
            mst--;
          end
        end else begin
          msl++;
          if (idx == 3) begin md[3] = d; mdp[3] = ~rs[i][7]; mst = 2; end
          else mst = -1;
        end
      end
    end

    v0 = nvalid; s0 = nsloss;
    first = expq.size();
    chk_on = 1'b1;
    for (int i = 0; i < NRND; i++) drive(rc[i], rs[i], rh[i]);
    drive(4'hF, 8'hFF, 2 * SETTLE + 4);
    chk_on = 1'b0;
    check("rnd_frames", nvalid - v0, first);
    check("rnd_leftover", expq.size(), 0);
    check("rnd_sloss", nsloss - s0, msl);
    check("rnd_perr", pattern_err, mperr);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
